// File: rtl/signed_div_seq.sv
// signed_div_seq: iterative WIDTH-bit signed divider, restoring radix-2, one quotient bit per clock.
// Optional build macro SIGNED_DIV_FASTPATH_EN: special cases and |a|<|b| bypass CALC (2-cycle latency).
`default_nettype none

module signed_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_VAL   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_pend_q, dz_pend_d;
  logic             ov_pend_q, ov_pend_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;
`ifdef SIGNED_DIV_FASTPATH_EN
  logic             small_q, small_d;
  logic             is_small;
`endif

  // Magnitudes are unsigned, so |-2^(WIDTH-1)| = 2^(WIDTH-1) fits without overflow.
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             is_dz, is_ov;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;

  assign abs_a = a[WIDTH-1] ? (ZERO - a) : a;
  assign abs_b = b[WIDTH-1] ? (ZERO - b) : b;
  assign is_dz = (b == ZERO);
  assign is_ov = (a == MIN_VAL) && (b == ALL_ONES);
`ifdef SIGNED_DIV_FASTPATH_EN
  assign is_small = (abs_a < abs_b);
`endif

  assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    dvd_d         = dvd_q;
    dvs_d         = dvs_q;
    a_d           = a_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    dz_pend_d     = dz_pend_q;
    ov_pend_d     = ov_pend_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    done_d        = 1'b0;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
`ifdef SIGNED_DIV_FASTPATH_EN
    small_d       = small_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          dvd_d     = abs_a;
          rem_d     = ZERO;
          dvs_d     = abs_b;
          a_d       = a;
          neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
          neg_rem_d = a[WIDTH-1];
          dz_pend_d = is_dz;
          ov_pend_d = is_ov;
          cnt_d     = '0;
`ifdef SIGNED_DIV_FASTPATH_EN
          small_d   = is_small;
          state_d   = (is_dz || is_ov || is_small) ? ST_FIX : ST_CALC;
`else
          state_d   = ST_CALC;
`endif
        end
      end

      ST_CALC: begin
        // Keep the trial difference when non-negative, otherwise restore the shifted value.
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = rem_shift[WIDTH-1:0];
          dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ITER) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        quotient_d    = neg_quo_q ? (ZERO - dvd_q) : dvd_q;
        remainder_d   = neg_rem_q ? (ZERO - rem_q) : rem_q;
        div_by_zero_d = dz_pend_q;
        overflow_d    = ov_pend_q;
        if (dz_pend_q) begin
          quotient_d  = ALL_ONES;
          remainder_d = a_q;
        end else if (ov_pend_q) begin
          quotient_d  = MIN_VAL;
          remainder_d = ZERO;
        end
`ifdef SIGNED_DIV_FASTPATH_EN
        else if (small_q) begin
          quotient_d  = ZERO;
          remainder_d = a_q;
        end
`endif
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      rem_q         <= ZERO;
      dvd_q         <= ZERO;
      dvs_q         <= ZERO;
      a_q           <= ZERO;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      dz_pend_q     <= 1'b0;
      ov_pend_q     <= 1'b0;
      quotient_q    <= ZERO;
      remainder_q   <= ZERO;
      done_q        <= 1'b0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef SIGNED_DIV_FASTPATH_EN
      small_q       <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      dvd_q         <= dvd_d;
      dvs_q         <= dvs_d;
      a_q           <= a_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      dz_pend_q     <= dz_pend_d;
      ov_pend_q     <= ov_pend_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      done_q        <= done_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
`ifdef SIGNED_DIV_FASTPATH_EN
      small_q       <= small_d;
`endif
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

`default_nettype wire
